tsmccim_16x8x11_m1: RTL and testbench
=====================================

TSMCCIM_16X8X11_M1 -- requirements
Module: tsmccim_16x8x11_m1

Interface
REQ-001 SHALL have parameter CORE_NUM, default 16, number of compute cores (banks).
REQ-002 SHALL have parameter XIN_BIT_WIDTH, default 11, per-core activation width (signed).
REQ-003 SHALL have parameter MEM_BIT_WIDTH, default 8, stored weight width (signed).
REQ-004 SHALL have parameter MEM_ADR_WIDTH, default 2, word address width per core (4 words).
REQ-005 SHALL derive CORE_DOUT_BIT_WIDTH = XIN_BIT_WIDTH+MEM_BIT_WIDTH-1 (18) and OUTPUT_BIT_WIDTH = CORE_DOUT_BIT_WIDTH+clog2(CORE_NUM) (22).
REQ-006 SHALL use one clock; reset is asynchronous and active-high.
REQ-007 CLK  input  1  clock; all state updates on rising edge.
REQ-008 RST  input  1  asynchronous active-high reset.
REQ-009 ENCB  input  1  active-low MAC (compute) enable.
REQ-010 WEB  input  1  active-low write enable, port A.
REQ-011 BANKA  input  clog2(CORE_NUM)  write core select.
REQ-012 ADRA  input  MEM_ADR_WIDTH  write word address.
REQ-013 D  input  MEM_BIT_WIDTH  write data.
REQ-014 REB  input  1  active-low read enable, port B.
REQ-015 BANKB  input  clog2(CORE_NUM)  read core select (ignored in MAC).
REQ-016 ADRB  input  MEM_ADR_WIDTH  read word address; also MAC word address for all cores.
REQ-017 XIN  input  CORE_NUM*XIN_BIT_WIDTH  activations; core i at bits [(i+1)*11-1 : i*11].
REQ-018 Q  output  OUTPUT_BIT_WIDTH  read data or MAC result, registered.

Function
REQ-019 Storage SHALL be CORE_NUM x 2^MEM_ADR_WIDTH words of MEM_BIT_WIDTH bits (16x4x8).
REQ-020 WEB low at rising edge SHALL write D to mem[BANKA][ADRA]; write is independent of REB/ENCB.
REQ-021 Operation SHALL be pipelined two stages: command (ENCB/REB, BANKB, ADRB, XIN) registered at edge N, Q updated at edge N+1; Q valid after second rising edge following sampling.
REQ-022 Read (ENCB high, REB low): Q SHALL become mem[BANKB][ADRB] zero-extended to 22 bits.
REQ-023 MAC (ENCB low, regardless of REB): Q SHALL become sum over i of signed(mem[i][ADRB]) * signed(XIN slice i).
REQ-024 Per-core product SHALL be truncated to 18 bits (two's complement); only -1024*-128 overflows, wrapping to -131072.
REQ-025 Products SHALL be sign-extended to 22 bits and summed; no overflow possible beyond that.
REQ-026 ENCB and REB both high SHALL leave Q holding its previous value.
REQ-027 Same-edge write and read/MAC to same word SHALL use old data (read-before-write).
REQ-028 Back-to-back commands SHALL be accepted every cycle (throughput 1/cycle, no stall).

Reset
REQ-029 RST high SHALL asynchronously clear Q, all pipeline registers and all memory words to 0.
REQ-030 Command in flight at reset SHALL be discarded; first valid Q two edges after first command post-release.

Structure
REQ-031 Package tsmccim_pkg SHALL hold the four default parameters and derived widths.
REQ-032 Sub-module tsmccim_core SHALL hold one core's 4x8 storage, write decode and signed 11x8 multiplier, instantiated CORE_NUM times; top holds adder tree and output register.

Verification
REQ-033 Reset: RST high mid-run -> Q=0 immediately; reads of all addresses return 0.
REQ-034 Write bank0 addr0..3 = AA,B1,C2,D3, then REB low ADRB 0..3 -> Q = 0000AA,0000B1,0000C2,0000D3 two edges after each.
REQ-035 MAC: bank0 addr0=02, bank1 addr0=FD, XIN core0=5, core1=7, others 0, ENCB low ADRB=0 -> Q=22'h3FFFF5 (-11).
REQ-036 MAC all 16 cores: weights 34,64,240,242,143,109,166,233,105,148,74,182,28,100,22,235; XIN 467,451,1645,818,1262,1105,1832,1011,871,464,1348,1808,1282,987,680,997 -> Q=22'h0188B6 (100534).
REQ-037 Corner: weight 80, XIN 400, others 0 -> Q=22'h3E0000 (truncation wrap).
REQ-038 Simultaneous write and read same word -> old value on Q; next read returns new value.

Source files
------------

// File: rtl/tsmccim_pkg.sv
// ---------------------------------------------------------------------------
// tsmccim_pkg
//   Shared defaults and helpers for the 16-core x 4-word x 8-bit compute-in-
//   memory macro model.
//
//   Contents
//     DEF_CORE_NUM, DEF_XIN_BIT_WIDTH, DEF_MEM_BIT_WIDTH, DEF_MEM_ADR_WIDTH
//       default geometry used by tsmccim_16x8x11_m1 and tsmccim_core
//     DEF_CORE_DOUT_BIT_WIDTH, DEF_OUTPUT_BIT_WIDTH
//       derived per-core product width and accumulated output width
//     op_e / decode_op()
//       the three things a sampled command can ask for: hold, read, MAC
// ---------------------------------------------------------------------------
package tsmccim_pkg;

  localparam int DEF_CORE_NUM      = 16;
  localparam int DEF_XIN_BIT_WIDTH = 11;
  localparam int DEF_MEM_BIT_WIDTH = 8;
  localparam int DEF_MEM_ADR_WIDTH = 2;

  // An 11x8 signed product needs 19 bits for the single case -1024*-128;
  // the macro keeps 18 and lets that one case wrap.
  localparam int DEF_CORE_DOUT_BIT_WIDTH = DEF_XIN_BIT_WIDTH + DEF_MEM_BIT_WIDTH - 1;
  localparam int DEF_OUTPUT_BIT_WIDTH    = DEF_CORE_DOUT_BIT_WIDTH + $clog2(DEF_CORE_NUM);

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,  // ENCB and REB both high: Q keeps its value
    OP_READ = 2'd1,  // ENCB high, REB low: Q <= stored word, zero-extended
    OP_MAC  = 2'd2   // ENCB low (REB ignored): Q <= dot product over cores
  } op_e;

  // MAC enable dominates the read enable.
  function automatic op_e decode_op(input logic encb, input logic reb);
    if (!encb)     return OP_MAC;
    else if (!reb) return OP_READ;
    else           return OP_HOLD;
  endfunction

endpackage : tsmccim_pkg

// File: rtl/tsmccim_core.sv
// ---------------------------------------------------------------------------
// tsmccim_core
//   One compute core (bank): a 2^MEM_ADR_WIDTH x MEM_BIT_WIDTH weight store,
//   its write decode, the command-stage capture of the addressed word and of
//   this core's activation slice, and the signed multiplier that turns them
//   into a truncated CORE_DOUT_BIT_WIDTH product.
//
//   Ports
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset (clears storage and capture)
//     web    in   active-low write enable (shared by all cores)
//     banka  in   write core select; this core writes when banka == CORE_IDX
//     adra   in   write word address
//     d      in   write data
//     adrb   in   read / MAC word address (same for every core)
//     xin    in   this core's signed activation
//     word   out  captured stored word (raw bits, for the read path)
//     prod   out  signed word * signed activation, truncated to
//                 CORE_DOUT_BIT_WIDTH bits
// ---------------------------------------------------------------------------
module tsmccim_core
  import tsmccim_pkg::*;
#(
  parameter int CORE_IDX            = 0,
  parameter int BANK_WIDTH          = $clog2(DEF_CORE_NUM),
  parameter int XIN_BIT_WIDTH       = DEF_XIN_BIT_WIDTH,
  parameter int MEM_BIT_WIDTH       = DEF_MEM_BIT_WIDTH,
  parameter int MEM_ADR_WIDTH       = DEF_MEM_ADR_WIDTH,
  parameter int CORE_DOUT_BIT_WIDTH = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  web,
  input  logic        [BANK_WIDTH-1:0]          banka,
  input  logic        [MEM_ADR_WIDTH-1:0]       adra,
  input  logic        [MEM_BIT_WIDTH-1:0]       d,
  input  logic        [MEM_ADR_WIDTH-1:0]       adrb,
  input  logic        [XIN_BIT_WIDTH-1:0]       xin,
  output logic        [MEM_BIT_WIDTH-1:0]       word,
  output logic signed [CORE_DOUT_BIT_WIDTH-1:0] prod
);

  localparam int WORDS = 1 << MEM_ADR_WIDTH;

  logic [MEM_BIT_WIDTH-1:0] mem [WORDS];
  logic [XIN_BIT_WIDTH-1:0] xin_q;
  logic                     wr_en;

  assign wr_en = !web && (banka == BANK_WIDTH'(CORE_IDX));

  // NOTE: the storage has a reset branch on purpose -- the macro must come
  // out of reset with every weight at zero, so it cannot map to a plain
  // RAM macro without reset; at 4 words per core flops are the right fit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[adra] <= d;
    end
  end

  // NOTE: non-blocking assignment is what gives read-before-write: a write
  // and a read of the same word on the same edge both see the value held
  // before the edge, regardless of the order these blocks are evaluated in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      xin_q <= '0;
    end else begin
      word  <= mem[adrb];
      xin_q <= xin;
    end
  end

  // Sign-extend both operands to the product width first; the multiply then
  // keeps only the low CORE_DOUT_BIT_WIDTH bits, which is exactly the two's
  // complement truncation the macro specifies (-1024 * -128 wraps negative).
  logic signed [CORE_DOUT_BIT_WIDTH-1:0] x_ext;
  logic signed [CORE_DOUT_BIT_WIDTH-1:0] w_ext;

  assign x_ext = CORE_DOUT_BIT_WIDTH'($signed(xin_q));
  assign w_ext = CORE_DOUT_BIT_WIDTH'($signed(word));
  assign prod  = x_ext * w_ext;

endmodule : tsmccim_core

// File: rtl/tsmccim_16x8x11_m1.sv
// ---------------------------------------------------------------------------
// tsmccim_16x8x11_m1
//   Compute-in-memory macro: CORE_NUM cores, each holding 2^MEM_ADR_WIDTH
//   signed MEM_BIT_WIDTH weights. Port A writes one word per cycle; port B
//   either reads one word out or, in MAC mode, multiplies the addressed word
//   of every core by that core's signed activation and sums the results.
//
//   Two-stage pipeline: the command is captured at edge N (with the stored
//   words as they were before any same-edge write), Q is updated at edge N+1.
//   A new command is accepted every cycle.
//
//   Ports
//     CLK    in   clock, rising edge
//     RST    in   asynchronous active-high reset: clears Q, pipeline, storage
//     ENCB   in   active-low MAC enable (wins over REB)
//     WEB    in   active-low write enable
//     BANKA  in   write core select
//     ADRA   in   write word address
//     D      in   write data
//     REB    in   active-low read enable
//     BANKB  in   read core select (unused in MAC)
//     ADRB   in   read / MAC word address
//     XIN    in   packed activations, core i at [(i+1)*XIN_BIT_WIDTH-1 -: XIN_BIT_WIDTH]
//     Q      out  registered read data (zero-extended) or MAC sum
// ---------------------------------------------------------------------------
module tsmccim_16x8x11_m1
  import tsmccim_pkg::*;
#(
  parameter  int CORE_NUM            = DEF_CORE_NUM,
  parameter  int XIN_BIT_WIDTH       = DEF_XIN_BIT_WIDTH,
  parameter  int MEM_BIT_WIDTH       = DEF_MEM_BIT_WIDTH,
  parameter  int MEM_ADR_WIDTH       = DEF_MEM_ADR_WIDTH,
  localparam int BANK_WIDTH          = $clog2(CORE_NUM),
  localparam int CORE_DOUT_BIT_WIDTH = XIN_BIT_WIDTH + MEM_BIT_WIDTH - 1,
  localparam int OUTPUT_BIT_WIDTH    = CORE_DOUT_BIT_WIDTH + $clog2(CORE_NUM)
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              ENCB,
  input  logic                              WEB,
  input  logic [BANK_WIDTH-1:0]             BANKA,
  input  logic [MEM_ADR_WIDTH-1:0]          ADRA,
  input  logic [MEM_BIT_WIDTH-1:0]          D,
  input  logic                              REB,
  input  logic [BANK_WIDTH-1:0]             BANKB,
  input  logic [MEM_ADR_WIDTH-1:0]          ADRB,
  input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0] XIN,
  output logic [OUTPUT_BIT_WIDTH-1:0]       Q
);

  // -------------------------------------------------------------------------
  // Cores: storage, same-edge capture of word + activation, multiplier
  // -------------------------------------------------------------------------
  logic        [MEM_BIT_WIDTH-1:0]       core_word [CORE_NUM];
  logic signed [CORE_DOUT_BIT_WIDTH-1:0] core_prod [CORE_NUM];

  for (genvar i = 0; i < CORE_NUM; i++) begin : g_core
    tsmccim_core #(
      .CORE_IDX            (i),
      .BANK_WIDTH          (BANK_WIDTH),
      .XIN_BIT_WIDTH       (XIN_BIT_WIDTH),
      .MEM_BIT_WIDTH       (MEM_BIT_WIDTH),
      .MEM_ADR_WIDTH       (MEM_ADR_WIDTH),
      .CORE_DOUT_BIT_WIDTH (CORE_DOUT_BIT_WIDTH)
    ) u_core (
      .clk   (CLK),
      .rst   (RST),
      .web   (WEB),
      .banka (BANKA),
      .adra  (ADRA),
      .d     (D),
      .adrb  (ADRB),
      .xin   (XIN[i*XIN_BIT_WIDTH +: XIN_BIT_WIDTH]),
      .word  (core_word[i]),
      .prod  (core_prod[i])
    );
  end

  // -------------------------------------------------------------------------
  // Command stage: operation and read bank, aligned with the core captures
  // -------------------------------------------------------------------------
  op_e                   op_q;
  logic [BANK_WIDTH-1:0] bankb_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q    <= OP_HOLD;
      bankb_q <= '0;
    end else begin
      op_q    <= decode_op(ENCB, REB);
      bankb_q <= BANKB;
    end
  end

  // -------------------------------------------------------------------------
  // Adder tree: sign-extend every truncated product to the output width and
  // sum. The output width carries clog2(CORE_NUM) guard bits, so the sum
  // itself never overflows; synthesis balances the chain into a tree.
  // -------------------------------------------------------------------------
  logic signed [OUTPUT_BIT_WIDTH-1:0] mac_sum;

  // NOTE: the accumulator is assigned before the loop so every path through
  // this block writes it -- no latch can be inferred.
  always_comb begin
    mac_sum = '0;
    for (int i = 0; i < CORE_NUM; i++) begin
      mac_sum = mac_sum + OUTPUT_BIT_WIDTH'(core_prod[i]);
    end
  end

  logic [MEM_BIT_WIDTH-1:0] read_word;
  assign read_word = core_word[bankb_q];

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q <= '0;
    end else begin
      case (op_q)
        OP_READ: Q <= OUTPUT_BIT_WIDTH'(read_word);  // unsigned: zero-extend
        OP_MAC:  Q <= mac_sum;
        default: Q <= Q;                             // hold
      endcase
    end
  end

endmodule : tsmccim_16x8x11_m1

// File: tb/tb_tsmccim_16x8x11_m1.sv
// ---------------------------------------------------------------------------
// tb_tsmccim_16x8x11_m1
//   Table of directed vectors with constant expectations, a few hand-written
//   multi-cycle sequences (read-before-write, mid-run reset), then random
//   traffic compared every cycle against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_tsmccim_16x8x11_m1;

  localparam int CN = 16;
  localparam int XW = 11;
  localparam int XV = CN * XW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          ENCB, WEB, REB;
  logic [3:0]    BANKA, BANKB;
  logic [1:0]    ADRA, ADRB;
  logic [7:0]    D;
  logic [XV-1:0] XIN;
  logic [21:0]   Q;

  always #5 CLK = ~CLK;

  tsmccim_16x8x11_m1 dut (
    .CLK   (CLK),
    .RST   (RST),
    .ENCB  (ENCB),
    .WEB   (WEB),
    .BANKA (BANKA),
    .ADRA  (ADRA),
    .D     (D),
    .REB   (REB),
    .BANKB (BANKB),
    .ADRB  (ADRB),
    .XIN   (XIN),
    .Q     (Q)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: Q=%06h expected %06h", name, act, exp);
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_idle();
    WEB = 1'b1; ENCB = 1'b1; REB = 1'b1;
    BANKA = '0; ADRA = '0; D = '0;
    BANKB = '0; ADRB = '0; XIN = '0;
  endtask

  function automatic logic [XV-1:0] put_xin(input logic [XV-1:0] base, input int core, input int val);
    logic [XV-1:0] r;
    r = base;
    r[core*XW +: XW] = 11'(val);
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // Directed vector table
  // -------------------------------------------------------------------------
  typedef struct {
    logic          web;
    logic [3:0]    banka;
    logic [1:0]    adra;
    logic [7:0]    d;
    logic          encb;
    logic          reb;
    logic [3:0]    bankb;
    logic [1:0]    adrb;
    logic [XV-1:0] xin;
    logic          chk;
    logic [21:0]   exp_q;
  } vec_t;

  function automatic vec_t v_wr(input int bank, input int adr, input int data);
    vec_t v;
    v = '{web: 1'b0, banka: 4'(bank), adra: 2'(adr), d: 8'(data), encb: 1'b1, reb: 1'b1,
          bankb: '0, adrb: '0, xin: '0, chk: 1'b0, exp_q: '0};
    return v;
  endfunction

  function automatic vec_t v_rd(input int bank, input int adr, input logic [21:0] exp);
    vec_t v;
    v = '{web: 1'b1, banka: '0, adra: '0, d: '0, encb: 1'b1, reb: 1'b0,
          bankb: 4'(bank), adrb: 2'(adr), xin: '0, chk: 1'b1, exp_q: exp};
    return v;
  endfunction

  function automatic vec_t v_mac(input int adr, input logic [XV-1:0] x, input logic reb,
                                 input logic [21:0] exp);
    vec_t v;
    v = '{web: 1'b1, banka: '0, adra: '0, d: '0, encb: 1'b0, reb: reb,
          bankb: 4'd7, adrb: 2'(adr), xin: x, chk: 1'b1, exp_q: exp};
    return v;
  endfunction

  function automatic vec_t v_hold(input logic [21:0] exp);
    vec_t v;
    v = '{web: 1'b1, banka: '0, adra: '0, d: '0, encb: 1'b1, reb: 1'b1,
          bankb: 4'd3, adrb: 2'd1, xin: '1, chk: 1'b1, exp_q: exp};
    return v;
  endfunction

  int w36 [CN] = '{34, 64, 240, 242, 143, 109, 166, 233, 105, 148, 74, 182, 28, 100, 22, 235};
  int x36 [CN] = '{467, 451, 1645, 818, 1262, 1105, 1832, 1011, 871, 464, 1348, 1808, 1282, 987, 680, 997};

  // -------------------------------------------------------------------------
  // Reference model: weights as integers, product wrap and sum by arithmetic
  // -------------------------------------------------------------------------
  int          mem_m [CN][4];
  logic [21:0] q_m;
  logic        pend_hold;
  logic [21:0] pend_val;

  function automatic int as_signed(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  function automatic logic [21:0] model_mac(input int adr, input logic [XV-1:0] x);
    int sum, p, xv;
    sum = 0;
    for (int i = 0; i < CN; i++) begin
      xv = int'(x[i*XW +: XW]);
      p  = as_signed(mem_m[i][adr], 8) * as_signed(xv, 11);
      if (p > 131071) p = p - 262144;  // 18-bit two's complement wrap
      sum += p;
    end
    return 22'(sum);
  endfunction

  initial begin
    vec_t        vecs [$];
    logic [XV-1:0] x;

    drive_idle();
    RST = 1'b1;
    #12;
    check("reset_q", Q, 22'h000000);
    @(negedge CLK);
    RST = 1'b0;
    step();

    // ---- build the vector table ----
    vecs.push_back(v_wr(0, 0, 8'hAA));
    vecs.push_back(v_wr(0, 1, 8'hB1));
    vecs.push_back(v_wr(0, 2, 8'hC2));
    vecs.push_back(v_wr(0, 3, 8'hD3));
    vecs.push_back(v_rd(0, 0, 22'h0000AA));
    vecs.push_back(v_rd(0, 1, 22'h0000B1));
    vecs.push_back(v_rd(0, 2, 22'h0000C2));
    vecs.push_back(v_rd(0, 3, 22'h0000D3));
    vecs.push_back(v_wr(0, 0, 8'h02));
    vecs.push_back(v_wr(1, 0, 8'hFD));
    x = put_xin('0, 0, 5);
    x = put_xin(x, 1, 7);
    vecs.push_back(v_mac(0, x, 1'b1, 22'h3FFFF5));
    vecs.push_back(v_hold(22'h3FFFF5));
    for (int i = 0; i < CN; i++) vecs.push_back(v_wr(i, 2, w36[i]));
    x = '0;
    for (int i = 0; i < CN; i++) x = put_xin(x, i, x36[i]);
    vecs.push_back(v_mac(2, x, 1'b1, 22'h0188B6));
    vecs.push_back(v_mac(2, x, 1'b0, 22'h0188B6));   // REB low too: still MAC
    vecs.push_back(v_rd(9, 2, 22'h000094));
    vecs.push_back(v_rd(3, 3, 22'h000000));
    vecs.push_back(v_wr(5, 3, 8'h80));
    vecs.push_back(v_mac(3, put_xin('0, 5, 11'h400), 1'b1, 22'h3E0000));

    // ---- apply: vector, one idle cycle, then Q carries its result ----
    foreach (vecs[k]) begin
      WEB = vecs[k].web;   BANKA = vecs[k].banka; ADRA = vecs[k].adra; D = vecs[k].d;
      ENCB = vecs[k].encb; REB = vecs[k].reb;     BANKB = vecs[k].bankb;
      ADRB = vecs[k].adrb; XIN = vecs[k].xin;
      step();
      drive_idle();
      step();
      if (vecs[k].chk) check($sformatf("vec%0d", k), Q, vecs[k].exp_q);
    end

    // ---- same-edge write and read of one word, then back-to-back reread ----
    WEB = 1'b0; BANKA = 4'd3; ADRA = 2'd1; D = 8'h11;
    step();
    WEB = 1'b0; BANKA = 4'd3; ADRA = 2'd1; D = 8'h5C;
    REB = 1'b0; BANKB = 4'd3; ADRB = 2'd1;
    step();
    WEB = 1'b1;
    step();
    check("rbw_old", Q, 22'h000011);
    drive_idle();
    step();
    check("rbw_new", Q, 22'h00005C);

    // ---- reset mid-run with a read in flight ----
    REB = 1'b0; BANKB = 4'd0; ADRB = 2'd3;
    step();
    RST = 1'b1;
    #1;
    check("rst_async", Q, 22'h000000);
    drive_idle();
    #1;
    RST = 1'b0;
    step();
    step();
    check("rst_discard", Q, 22'h000000);
    for (int b = 0; b < CN; b++) begin
      for (int a = 0; a < 4; a++) begin
        REB = 1'b0; BANKB = 4'(b); ADRB = 2'(a);
        step();
        drive_idle();
        step();
        check($sformatf("rst_mem_b%0d_a%0d", b, a), Q, 22'h000000);
      end
    end

    // ---- random traffic against the model, one command per cycle ----
    for (int b = 0; b < CN; b++)
      for (int a = 0; a < 4; a++) mem_m[b][a] = 0;
    q_m       = '0;
    pend_hold = 1'b1;
    pend_val  = '0;
    drive_idle();
    step();
    step();
    for (int c = 0; c < 500; c++) begin
      WEB   = ($urandom_range(0, 1) == 0);
      BANKA = 4'($urandom_range(0, CN - 1));
      ADRA  = 2'($urandom_range(0, 3));
      D     = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      ENCB  = ($urandom_range(0, 9) >= 4);
      REB   = ($urandom_range(0, 1) == 0);
      BANKB = 4'($urandom_range(0, CN - 1));
      ADRB  = 2'($urandom_range(0, 3));
      for (int i = 0; i < CN; i++)
        XIN[i*XW +: XW] = ($urandom_range(0, 3) == 0) ? 11'h400 : 11'($urandom_range(0, 2047));
      step();
      // Model of the edge just taken: finish the previous command, sample
      // the new one against the pre-write contents, then apply the write.
      if (!pend_hold) q_m = pend_val;
      if (!ENCB) begin
        pend_hold = 1'b0;
        pend_val  = model_mac(int'(ADRB), XIN);
      end else if (!REB) begin
        pend_hold = 1'b0;
        pend_val  = 22'(mem_m[BANKB][ADRB]);
      end else begin
        pend_hold = 1'b1;
      end
      if (!WEB) mem_m[BANKA][ADRA] = int'(D);
      check($sformatf("rand%0d", c), Q, q_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_tsmccim_16x8x11_m1
